// File: rtl/fft_agu.sv
// Address generator and sequencer for an in-place 64-point radix-2 DIT FFT.
// Drives sample-RAM read/write addresses and twiddle-ROM addresses, and tags returning RAM data.
module fft_agu #(
  parameter int BFLY_LAT = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic [5:0] read_address,
  output logic [5:0] write_address,
  output logic       write,
  output logic [4:0] twiddle_address,
  output logic       rd_valid,
  output logic       rd_phase,
  output logic       busy,
  output logic       done
);

  localparam int WR_DLY = BFLY_LAT + 2;
  localparam int DCW    = $clog2(WR_DLY + 1);
  localparam int DL_LEN = WR_DLY - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       stage_q, stage_d;
  logic [4:0]       bfly_q, bfly_d;
  logic             phase_q, phase_d;
  logic [DCW-1:0]   drain_q, drain_d;
  logic [5:0]       raddr_q, raddr_d;
  logic [4:0]       twid_q, twid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_valid_q, rd_phase_q;
  logic             dl_valid_q [DL_LEN];
  logic [5:0]       dl_addr_q  [DL_LEN];
  logic             write_q;
  logic [5:0]       waddr_q;

  function automatic logic [5:0] rotl6(input logic [5:0] v, input logic [2:0] s);
    logic [11:0] t;
    t = {v, v} << s;
    return t[11:6];
  endfunction

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    phase_d = phase_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          stage_d = 3'd0;
          bfly_d  = 5'd0;
          phase_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        phase_d = ~phase_q;
        if (phase_q) begin
          bfly_d = bfly_q + 5'd1;
          if (bfly_q == 5'd31) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end else begin
            state_d = S_READ;
          end
        end else begin
          bfly_d = bfly_q;
        end
      end
      S_DRAIN: begin
        // Hold off the next stage until the last write of this one has issued.
        if (drain_q == DCW'(WR_DLY - 1)) begin
          if (stage_q == 3'd5) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
            stage_d = stage_q + 3'd1;
          end
        end else begin
          drain_d = drain_q + DCW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_READ) begin
      raddr_d = rotl6({bfly_d, phase_d}, stage_d);
      if (!phase_d) begin
        twid_d = bfly_d & ~(5'h1F >> stage_d);
      end else begin
        twid_d = twid_q;
      end
    end else begin
      raddr_d = 6'd0;
      twid_d  = 5'd0;
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // FSM, counters and address registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      stage_q <= 3'd0;
      bfly_q  <= 5'd0;
      phase_q <= 1'b0;
      drain_q <= '0;
      raddr_q <= 6'd0;
      twid_q  <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
      phase_q <= phase_d;
      drain_q <= drain_d;
      raddr_q <= raddr_d;
      twid_q  <= twid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Read-data tags and the write-delay line (read address replayed WR_DLY cycles later).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_phase_q <= 1'b0;
      for (int j = 0; j < DL_LEN; j++) begin
        dl_valid_q[j] <= 1'b0;
        dl_addr_q[j]  <= 6'd0;
      end
      write_q <= 1'b0;
      waddr_q <= 6'd0;
    end else begin
      rd_valid_q    <= (state_q == S_READ);
      rd_phase_q    <= (state_q == S_READ) & phase_q;
      dl_valid_q[0] <= (state_q == S_READ);
      dl_addr_q[0]  <= raddr_q;
      for (int j = 1; j < DL_LEN; j++) begin
        dl_valid_q[j] <= dl_valid_q[j-1];
        dl_addr_q[j]  <= dl_addr_q[j-1];
      end
      write_q <= dl_valid_q[DL_LEN-1];
      waddr_q <= dl_addr_q[DL_LEN-1];
    end
  end

  assign read_address    = raddr_q;
  assign twiddle_address = twid_q;
  assign write           = write_q;
  assign write_address   = waddr_q;
  assign rd_valid        = rd_valid_q;
  assign rd_phase        = rd_phase_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
